// File: rtl/ps_len_prepender.sv
// ps_len_prepender: store-and-forward stage that buffers one slice of up
// to MAXLEN words, emits a length header word, then replays the slice.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - async reset, active low
//   i_dat  - inbound data        i_val - inbound valid
//   i_eop  - inbound end of pkt  i_rdy - inbound ready
//   o_dat  - header or payload   o_val - outbound valid
//   o_eop  - last payload word   o_rdy - outbound ready
module ps_len_prepender #(
  parameter int WIDTH  = 8,
  parameter int MAXLEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_val,
  input  logic             i_eop,
  output logic             i_rdy,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_val,
  output logic             o_eop,
  input  logic             o_rdy
);

  localparam int CW = $clog2(MAXLEN + 1);
  localparam int AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(MAXLEN - 1);

  typedef enum logic [1:0] {
    FILL,
    HEAD,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] len_q, len_d;
  logic          run_q;
  logic          wr_en;

  logic [WIDTH-1:0] mem_q [MAXLEN];

  logic [AW-1:0] wa;
  logic [AW-1:0] ra;

  assign wa = wcnt_q[AW-1:0];
  assign ra = rcnt_q[AW-1:0];

  // run_q keeps i_rdy low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      len_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      len_q   <= len_d;
      run_q   <= 1'b1;
    end
  end

  // Payload storage carries no reset; stale words are never read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wa] <= i_dat;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    len_d   = len_q;
    wr_en   = 1'b0;
    i_rdy   = 1'b0;
    o_val   = 1'b0;
    o_eop   = 1'b0;
    o_dat   = '0;

    unique case (state_q)
      FILL: begin
        i_rdy = run_q;
        if (i_val && run_q) begin
          wr_en  = 1'b1;
          wcnt_d = wcnt_q + ONE;
          // Close on eop or on the word that fills the buffer.
          if (i_eop || (wcnt_q == LAST)) begin
            len_d   = wcnt_q + ONE;
            state_d = HEAD;
          end
        end
      end

      HEAD: begin
        o_val = 1'b1;
        o_dat = WIDTH'(len_q);
        if (o_rdy) begin
          rcnt_d  = '0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        o_val = 1'b1;
        o_dat = mem_q[ra];
        o_eop = (rcnt_q == (len_q - ONE));
        if (o_rdy) begin
          rcnt_d = rcnt_q + ONE;
          if (o_eop) begin
            wcnt_d  = '0;
            state_d = FILL;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

endmodule

// File: doc/ps_len_prepender.md
Name: ps_len_prepender

Overview:
- Store-and-forward PacketStream stage placed directly downstream of the stream slicer.
- Buffers one slice of up to MAXLEN words and counts its words.
- Emits a single header word carrying the slice length, then replays the buffered slice unchanged with EOP on the last word.
- Gives downstream consumers, such as framers and DMA writers, the length of each slice before its first data word.

Parameters:
- WIDTH, 8: stream data width in bits. Must satisfy WIDTH >= $clog2(MAXLEN+1).
- MAXLEN, 4: maximum slice length in words, which is also the buffer depth. Must be >= 1.

Ports:
- clk  input  1  clock, rising edge active.
- rst  input  1  reset, asynchronous, active-low. rst=0 resets the block.
- i_dat  input  WIDTH  inbound data.
- i_val  input  1  inbound valid.
- i_eop  input  1  inbound end of packet.
- i_rdy  output  1  inbound ready.
- o_dat  output  WIDTH  outbound data (header or payload).
- o_val  output  1  outbound valid.
- o_eop  output  1  outbound end of packet.
- o_rdy  input  1  outbound ready.

Behaviour:
- Handshake rules:
  - A transfer occurs on a rising clk edge with val & rdy on that interface.
  - Once o_val is asserted, o_dat, o_val and o_eop hold stable until accepted.
  - i_rdy never depends on i_val.
- States: FILL (reset state), HEAD, DRAIN.
- FILL:
  - i_rdy=1, o_val=0.
  - Each accepted word is written to buf[wcnt] and wcnt is incremented (range 0..MAXLEN).
  - The slice closes on an accepted word with i_eop=1, or on the accepted word that makes wcnt reach MAXLEN, whichever comes first.
  - At close, len <= wcnt+1 (value 1..MAXLEN) and state <= HEAD.
  - Forced close at MAXLEN without i_eop: the next accepted word starts a new slice.
- HEAD:
  - i_rdy=0, o_val=1, o_dat = len zero-extended to WIDTH, o_eop=0.
  - On o_rdy: rcnt <= 0, state <= DRAIN.
- DRAIN:
  - i_rdy=0, o_val=1, o_dat = buf[rcnt], o_eop = (rcnt == len-1).
  - On o_rdy: rcnt increments.
  - On the transfer where o_eop=1: wcnt <= 0, state <= FILL.
- Latency: the header is presented the cycle after the closing input word is accepted.
  - Slice of L words occupies L input cycles plus at least L+1 output cycles.
  - No overlap between fill and drain.
- No empty slices: len is never 0.
  - A 1-word slice gives a header of 1 followed by one word with o_eop=1.
- i_val gaps during FILL pause counting. o_rdy low in HEAD or DRAIN holds the current word.
- Input words are never dropped or reordered. Payload output equals the input words in order.
- Reset (rst=0, any time, including mid-drain):
  - state=FILL, wcnt=0, rcnt=0, len=0.
  - o_val=0, o_eop=0. i_rdy=0 while rst=0 and 1 from the first clk edge after release.
  - Buffered data is discarded. buf contents need no reset.
- o_dat when o_val=0 is don't-care. It is driven 0 out of reset.

Test Plan:
All scenarios use WIDTH=8, MAXLEN=4 unless noted.
- 3-word packet A0,A1,A2(eop), o_rdy=1 → output 0x03, A0, A1, A2(o_eop). i_rdy=0 from the cycle after A2 is accepted until A2 is output.
- 1-word packet B0(eop) → output 0x01, B0(o_eop). i_rdy returns to 1 the cycle after B0 is output.
- 6-word packet w0..w5, eop only on w5 → output 0x04, w0..w3(o_eop), then 0x02, w4, w5(o_eop).
- Exactly 4 words with eop on w3 → single slice 0x04, w0..w3(o_eop) and no extra empty slice.
- o_rdy pattern 1,0,0,1,0,1... during HEAD/DRAIN → each word held stable while o_rdy=0. Sequence matches the first scenario.
- rst pulsed low during DRAIN after the header and one payload word → o_val=0 immediately, i_rdy=1 after release. A following 2-word packet C0,C1 outputs 0x02, C0, C1(o_eop).
- i_val pattern 1,0,1,0,1 during FILL of a 3-word packet → same output as the first scenario.
- MAXLEN=1 → every input word produces 0x01, word(o_eop).
